// File: rtl/uart_rx_ctrl_pkg.sv
// Shared state encoding and default frame geometry for the UART receive controller.
// Pure declarations: no latency, no flow control.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_ctrl_sync2.sv
// Two-flop synchroniser for an asynchronous level; 2 clk latency, no backpressure.
// Reset value is a parameter so an idle-high line stays idle through reset.
module uart_rx_ctrl_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive FSM feeding a SIPO: one registered shift pulse per data bit, LSB first, then rx_done.
// Line-to-detect latency 2 clks; no backpressure, the SIPO must accept every shift pulse.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS  = DEF_DATA_BITS,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic clk,
  input  logic clear,
  input  logic rx_in,
  input  logic baud_tick,
  output logic shift,
  output logic sipo_bit,
  output logic rx_done,
  output logic parity_err,
  output logic frame_err,
  output logic busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e     state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          rx_s;
  logic          par_acc, par_nxt;
  logic          perr_n, perr_n_nxt;
  logic          shift_nxt, sipo_nxt, done_nxt, perr_nxt, ferr_nxt;

  uart_rx_ctrl_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .clear (clear),
    .d     (rx_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
    end
  end

  // The tick that causes a transition restarts the count instead of advancing it.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    if (baud_tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_nxt = ST_START;
            tick_nxt  = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == TICK_HALF) begin
            state_nxt = rx_s ? ST_IDLE : ST_DATA;
            tick_nxt  = '0;
            bit_nxt   = '0;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (tick_cnt == TICK_FULL) begin
            tick_nxt = '0;
            bit_nxt  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              state_nxt = PARITY_EN ? ST_PARITY : ST_STOP;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (tick_cnt == TICK_FULL) begin
            state_nxt = ST_STOP;
            tick_nxt  = '0;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (tick_cnt == TICK_FULL) begin
            state_nxt = rx_s ? ST_IDLE : ST_WAIT_IDLE;
            tick_nxt  = '0;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state != ST_IDLE);
    shift_nxt  = 1'b0;
    done_nxt   = 1'b0;
    sipo_nxt   = sipo_bit;
    perr_nxt   = parity_err;
    ferr_nxt   = frame_err;
    par_nxt    = par_acc;
    perr_n_nxt = perr_n;
    if (baud_tick) begin
      case (state)
        ST_START: begin
          if (tick_cnt == TICK_HALF && !rx_s) begin
            par_nxt = PARITY_ODD;
          end
        end
        ST_DATA: begin
          if (tick_cnt == TICK_FULL) begin
            shift_nxt = 1'b1;
            sipo_nxt  = rx_s;
            par_nxt   = par_acc ^ rx_s;
          end
        end
        ST_PARITY: begin
          if (tick_cnt == TICK_FULL) begin
            perr_n_nxt = rx_s ^ par_acc;
          end
        end
        ST_STOP: begin
          if (tick_cnt == TICK_FULL) begin
            done_nxt = 1'b1;
            ferr_nxt = ~rx_s;
            perr_nxt = PARITY_EN ? perr_n : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Error flags only move together with rx_done and hold until the next frame.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      shift      <= 1'b0;
      sipo_bit   <= 1'b0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      par_acc    <= 1'b0;
      perr_n     <= 1'b0;
    end else begin
      shift      <= shift_nxt;
      sipo_bit   <= sipo_nxt;
      rx_done    <= done_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      par_acc    <= par_nxt;
      perr_n     <= perr_n_nxt;
    end
  end

endmodule
